swap_pipe_stage: RTL and testbench

Registered, flow-controlled stage that takes operand pairs (a, b) and produces them either passed through or swapped. The swap decision comes from an external select or an unsigned a>b compare. It sits directly downstream of the operand source and feeds the combinational swap/buffer datapath consumers, adding valid/ready handshaking and 2-entry buffering. It also provides a saturating count of swaps performed, used for sort and debug statistics.

---
 rtl/swap_pipe_pkg.sv | 18 +
 rtl/swap_pipe_stage_swap_core.sv | 15 +
 rtl/swap_pipe_stage.sv | 161 ++++++++++++++++
 tb/tb_swap_pipe_stage.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/swap_pipe_pkg.sv
// Shared definitions for the swap pipeline stage: FSM encoding and the layout
// of one buffered entry {a, b, swapped}.
package swap_pipe_pkg;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam int ENTRY_SWAP_W = 1;

    // Width of one stored entry: two operands plus the swapped flag.
    function automatic int entry_width(input int operand_w);
        return 2 * operand_w + ENTRY_SWAP_W;
    endfunction

endpackage

// File: rtl/swap_pipe_stage_swap_core.sv
// Combinational operand swapper: two crossed 2:1 muxes steered by sel.
module swap_core #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             sel,
    output logic [WIDTH-1:0] a_o,
    output logic [WIDTH-1:0] b_o
);

    assign a_o = sel ? in_b : in_a;
    assign b_o = sel ? in_a : in_b;

endmodule

// File: rtl/swap_pipe_stage.sv
// Registered valid/ready stage that buffers up to two swapped-or-passed operand
// pairs and keeps a saturating count of accepted swapped pairs.
//
// Handshake: a transfer happens on an edge where valid && ready are both high.
// Producers hold payload stable while valid is high and ready is low; in_ready
// depends only on the stage state, never on out_ready.
module swap_pipe_stage
    import swap_pipe_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_swap,
    input  logic             in_cmp_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_a,
    output logic [WIDTH-1:0] out_b,
    output logic             out_swapped,
    output logic [CNT_W-1:0] swap_count,
    output logic             busy
);

    localparam int ENTRY_W = entry_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_state_nxt;
    logic [ENTRY_W-1:0] r_slot [2];
    logic               r_rd_ptr;
    logic [CNT_W-1:0]   r_swap_count;

    logic               w_sel;
    logic [WIDTH-1:0]   w_core_a;
    logic [WIDTH-1:0]   w_core_b;
    logic               w_in_ready;
    logic               w_out_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_wr_idx;
    logic [ENTRY_W-1:0] w_head;
    logic [ENTRY_W-1:0] w_new_entry;

    // Equal operands never swap in compare mode (strict greater-than).
    assign w_sel = in_cmp_en ? (in_a > in_b) : in_swap;

    swap_core #(
        .WIDTH(WIDTH)
    ) u_swap_core (
        .in_a (in_a),
        .in_b (in_b),
        .sel  (w_sel),
        .a_o  (w_core_a),
        .b_o  (w_core_b)
    );

    assign w_new_entry = {w_core_a, w_core_b, w_sel};

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_EMPTY;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and state-derived handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b1;
        w_out_valid = 1'b0;
        case (r_state)
            ST_EMPTY: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b0;
                if (w_push) begin
                    w_state_nxt = ST_ONE;
                end
            end
            ST_ONE: begin
                w_in_ready  = 1'b1;
                w_out_valid = 1'b1;
                if (w_push && !w_pop) begin
                    w_state_nxt = ST_FULL;
                end else if (w_pop && !w_push) begin
                    w_state_nxt = ST_EMPTY;
                end
            end
            ST_FULL: begin
                w_in_ready  = 1'b0;
                w_out_valid = 1'b1;
                if (w_pop) begin
                    w_state_nxt = ST_ONE;
                end
            end
            default: begin
                w_state_nxt = ST_EMPTY;
                w_in_ready  = 1'b0;
                w_out_valid = 1'b0;
            end
        endcase
    end

    assign w_push = in_valid && w_in_ready;
    assign w_pop  = w_out_valid && out_ready;

    // When occupied, the free slot is the one opposite the head; this also
    // covers push+pop in ONE, where the new entry becomes the next head.
    assign w_wr_idx = (r_state == ST_EMPTY) ? r_rd_ptr : ~r_rd_ptr;

    // ------------------------------------------------------------------
    // Two-slot storage with a 1-bit read pointer
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_slot[0] <= '0;
            r_slot[1] <= '0;
            r_rd_ptr  <= 1'b0;
        end else begin
            if (w_push) begin
                r_slot[w_wr_idx] <= w_new_entry;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating swap statistics counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_swap_count <= '0;
        end else if (w_push && w_sel && (r_swap_count != CNT_MAX)) begin
            r_swap_count <= r_swap_count + CNT_ONE;
        end
    end

    assign w_head      = r_slot[r_rd_ptr];
    assign in_ready    = w_in_ready;
    assign out_valid   = w_out_valid;
    assign out_a       = w_head[ENTRY_W-1 -: WIDTH];
    assign out_b       = w_head[WIDTH : ENTRY_SWAP_W];
    assign out_swapped = w_head[0];
    assign swap_count  = r_swap_count;
    assign busy        = (r_state != ST_EMPTY);

endmodule

// File: tb/tb_swap_pipe_stage.sv
// Scoreboard bench for swap_pipe_stage: directed pairs push expected results,
// a negedge monitor pops and compares every output transfer.
module tb_swap_pipe_stage;

    localparam int WIDTH = 8;
    localparam int CNT_W = 2;
    localparam int W     = 2 * WIDTH + 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_swap;
    logic             in_cmp_en;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_a;
    logic [WIDTH-1:0] out_b;
    logic             out_swapped;
    logic [CNT_W-1:0] swap_count;
    logic             busy;

    logic [W-1:0] exp_q[$];
    int n_cmp = 0;
    int n_err = 0;

    swap_pipe_stage #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_a        (in_a),
        .in_b        (in_b),
        .in_swap     (in_swap),
        .in_cmp_en   (in_cmp_en),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_a       (out_a),
        .out_b       (out_b),
        .out_swapped (out_swapped),
        .swap_count  (swap_count),
        .busy        (busy)
    );

    // ---------------- clock / watchdog ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    // ---------------- checker ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_output", 32'(out_valid), 32'd0);
            end else begin
                check("out_pair", 32'({out_a, out_b, out_swapped}), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- driver tasks ----------------
    // Called at #1 after a rising edge; returns #1 after the accepting edge.
    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic cmp,
                        input logic swp, input logic [7:0] ea, input logic [7:0] eb,
                        input logic es);
        logic rdy;
        int   waited;
        waited    = 0;
        in_valid  = 1'b1;
        in_a      = a;
        in_b      = b;
        in_cmp_en = cmp;
        in_swap   = swp;
        forever begin
            rdy = in_ready;
            if (rdy) exp_q.push_back({ea, eb, es});
            @(posedge clk);
            #1;
            if (rdy) break;
            waited++;
            if (waited > 50) begin
                check("send_timeout", 32'd0, 32'd1);
                break;
            end
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_a     = 'x;
        in_b     = 'x;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] a;
        logic [7:0] b;
        logic       cmp;
        logic       swp;
        logic       es;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_a      = '0;
        in_b      = '0;
        in_swap   = 1'b0;
        in_cmp_en = 1'b0;
        out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset then idle
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_swap_count", 32'(swap_count), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_out_a", 32'(out_a), 32'd0);
        idle(1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // Compare mode
        out_ready = 1'b1;
        send(8'h05, 8'h03, 1'b1, 1'b0, 8'h03, 8'h05, 1'b1);
        check("cmp_count_1", 32'(swap_count), 32'd1);
        send(8'h03, 8'h03, 1'b1, 1'b1, 8'h03, 8'h03, 1'b0);
        check("cmp_equal_count", 32'(swap_count), 32'd1);
        idle(2);

        // External select
        send(8'hAA, 8'h55, 1'b0, 1'b0, 8'hAA, 8'h55, 1'b0);
        send(8'hAA, 8'h55, 1'b0, 1'b1, 8'h55, 8'hAA, 1'b1);
        idle(2);
        check("ext_count", 32'(swap_count), 32'd2);

        // Backpressure: third pair must be refused
        out_ready = 1'b0;
        send(8'h11, 8'h22, 1'b1, 1'b0, 8'h11, 8'h22, 1'b0);
        send(8'h44, 8'h33, 1'b1, 1'b0, 8'h33, 8'h44, 1'b1);
        in_valid  = 1'b1;
        in_a      = 8'h77;
        in_b      = 8'h66;
        in_cmp_en = 1'b1;
        repeat (3) begin
            check("bp_in_ready", 32'(in_ready), 32'd0);
            check("bp_busy", 32'(busy), 32'd1);
            check("bp_head_stable", 32'({out_a, out_b, out_swapped}), 32'({8'h11, 8'h22, 1'b0}));
            @(posedge clk);
            #1;
        end
        check("bp_count_sat", 32'(swap_count), 32'd3);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("bp_ready_after_pop", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        check("bp_drained", 32'(out_valid), 32'd0);

        // Mid-operation reset while FULL
        out_ready = 1'b0;
        send(8'h01, 8'h02, 1'b0, 1'b1, 8'h02, 8'h01, 1'b1);
        send(8'h03, 8'h04, 1'b0, 1'b1, 8'h04, 8'h03, 1'b1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        rst_n = 1'b0;
        exp_q.delete();
        in_valid  = 1'b1;
        in_a      = 8'hFF;
        in_b      = 8'h00;
        in_cmp_en = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_out_valid", 32'(out_valid), 32'd0);
        check("mrst_count", 32'(swap_count), 32'd0);
        check("mrst_busy", 32'(busy), 32'd0);
        in_valid  = 1'b0;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        idle(3);
        check("mrst_no_stale", 32'(out_valid), 32'd0);
        check("mrst_count_idle", 32'(swap_count), 32'd0);

        // Saturation: 5 swapped pushes on a 2-bit counter
        for (int i = 1; i <= 5; i++) begin
            send(8'h09, 8'h01, 1'b1, 1'b0, 8'h01, 8'h09, 1'b1);
            if (i == 2) check("sat_count_2", 32'(swap_count), 32'd2);
            if (i >= 3) check("sat_count_hold", 32'(swap_count), 32'd3);
        end
        idle(2);

        // 100 back-to-back pairs with simultaneous push/pop
        for (int i = 0; i < 100; i++) begin
            a   = 8'((i * 37) & 8'hFF);
            b   = 8'((255 - i * 11) & 8'hFF);
            cmp = (i % 3) != 0;
            swp = i[0];
            es  = cmp ? (a > b) : swp;
            send(a, b, cmp, swp, es ? b : a, es ? a : b, es);
            check("burst_out_valid", 32'(out_valid), 32'd1);
        end
        idle(3);
        check("queue_empty", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end

endmodule
